rr_grant_encoder: RTL and testbench
===================================

# rr_grant_encoder

Round-robin arbiter for eight requesters that emits the winning requester as a 3-bit index plus a valid flag. It sits directly upstream of the 3-to-8 decoder stage: `gnt_idx` drives the decoder's `in` and `gnt_valid` drives its `en`. It holds each grant until the owner signals completion, withdraws its request, or a hold timeout expires, then rotates priority.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held before forced release.
  - Range 0 to 255.
  - 0 disables the timeout.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request vector; bit i = requester i.
- `done`  in  1  current grantee finished; sampled only while granting.
- `gnt_idx`  out  3  index of granted requester; feeds decoder `in`.
- `gnt_valid`  out  1  grant active; feeds decoder `en`.
- `timeout`  out  1  one-cycle pulse on forced release.

## Operation
- **State machine:** two states, IDLE and GRANT. Reset enters IDLE.
- **Priority pointer `ptr`** (3 bits, reset 0): the requester checked first.
  - Search order is ptr, ptr+1, …, 7, 0, …, ptr−1 (mod 8).
- **IDLE:**
  - If `req != 0`, select the first set bit in search order.
  - Load its index into `gnt_idx` and clear the hold counter.
  - Go to GRANT.
  - If `req == 0`, stay in IDLE.
  - `done` is ignored in IDLE.
- **GRANT:** release when any of the following hold at a clock edge:
  - (a) `done` = 1;
  - (b) `req[gnt_idx]` = 0 (withdrawal);
  - (c) `MAX_HOLD != 0` and the hold counter = MAX_HOLD−1.
- **On release:**
  - `ptr` ← `gnt_idx` + 1, modulo 8 (7 wraps to 0).
  - Go to IDLE.
- **Hold counter:**
  - Width 8, unsigned.
  - Increments each cycle in GRANT, saturating at 255.
  - Cleared on grant.
- **`timeout`:** pulses for one cycle only when release is due solely to cause (c).
  - If (a) or (b) coincides with (c), the release counts as normal and `timeout` stays 0.
- **Other requests during GRANT:** changes on other `req` bits have no effect until the next IDLE.
- **`gnt_idx` while invalid:** holds its last granted value while `gnt_valid` = 0. Downstream must qualify with `gnt_valid`.

## Timing
- **Reset values:**
  - State IDLE, `ptr` = 0, hold counter 0.
  - `gnt_idx` = 3'd0, `gnt_valid` = 0, `timeout` = 0.
  - Reset takes effect immediately, with no clock edge required, including mid-grant: `gnt_valid` drops asynchronously.
- **All outputs are registered.**
- **Grant latency:**
  - `req` sampled at edge T in IDLE.
  - `gnt_valid` = 1 and `gnt_idx` valid from T (visible after the edge), i.e. one cycle after the request is first presented.
- **Release:**
  - `done`, withdrawal, or timeout sampled at edge T.
  - `gnt_valid` = 0 after T.
  - `timeout` is high for the cycle after T only.
- **Re-grant:** at least one IDLE cycle between grants, so the minimum grant-to-grant spacing is the grant length + 1 cycle.
- **Grant length:** with `MAX_HOLD` = N (N > 0) and no `done`/withdrawal, `gnt_valid` is high for exactly N cycles.
- **Simultaneous events:**
  - A new `req` and `done` in the same cycle do not shorten the IDLE gap.
  - `done` on the grant cycle itself is not possible, because the grant cycle is IDLE.

## Test plan
- **Reset and first grant:** reset, then `req` = 8'b0000_0000 for 3 cycles → `gnt_valid` = 0, `gnt_idx` = 0. Then `req` = 8'b0010_0100 → next cycle `gnt_idx` = 2, `gnt_valid` = 1.
- **Rotation:**
  - Hold `req` = 8'hFF and pulse `done` one cycle after each grant.
  - Required grant sequence: 0,1,2,…,7,0.
  - Each `gnt_valid` high for 1 cycle, with one low cycle between grants.
- **Wrap:**
  - Grant 7 via `req` = 8'h80, then `done`.
  - Next, with `req` = 8'h81, grant 0 (`ptr` wrapped to 0), not 7.
- **Timeout:**
  - `MAX_HOLD` = 4, `req` = 8'h08 held, no `done`.
  - `gnt_idx` = 3, `gnt_valid` high exactly 4 cycles.
  - `timeout` pulses once in the cycle `gnt_valid` falls.
  - Then regrant 3 after one idle cycle.
  - Repeat with `done` asserted on the 4th cycle → `timeout` stays 0.
- **Withdrawal:** grant requester 5 with `req` = 8'h20, then drop `req` to 0 → `gnt_valid` falls the next cycle, `ptr` = 6, `timeout` = 0.
- **Reset mid-grant:** assert `rst_n` = 0 while `gnt_valid` = 1 with `gnt_idx` = 6. Required behaviour:
  - `gnt_valid` goes to 0 without waiting for a clock edge, and `gnt_idx` = 0.
  - After release with `req` = 8'h41, the grant goes to 0.

Source files
------------

// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: eight-way round-robin arbiter emitting a registered grant index, valid flag and timeout pulse
module rr_grant_encoder #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    state_t     r_state, w_state;
    logic [2:0] r_ptr, w_ptr, r_idx, w_idx, w_sel;
    logic [7:0] r_cnt, w_cnt;
    logic       r_to, w_to, w_hit, w_rel;
    // first set request bit in search order ptr, ptr+1, ... wrapping mod 8
    always_comb begin
        w_sel = r_ptr;
        for (int k = 7; k >= 0; k--) if (req[r_ptr + 3'(k)]) w_sel = r_ptr + 3'(k);
    end
    // next-state: grant from IDLE, release on done/withdrawal/hold limit, count hold cycles
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_to    = 1'b0;
        w_hit   = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);
        w_rel   = done || !req[r_idx] || w_hit;
        if (r_state == IDLE) begin
            if (req != 8'd0) begin
                w_state = GRANT;
                w_idx   = w_sel;
                w_cnt   = 8'd0;
            end
        end else if (w_rel) begin
            w_state = IDLE;
            w_ptr   = r_idx + 3'd1;
            w_to    = w_hit && !done && req[r_idx];
        end else begin
            w_cnt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        end
    end
    // state and output registers; reset clears the grant without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_idx   <= 3'd0;
            r_cnt   <= 8'd0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_to    <= w_to;
        end
    end
    assign gnt_idx   = r_idx;
    assign gnt_valid = (r_state == GRANT);
    assign timeout   = r_to;
endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: directed checks of grant order, wrap, timeout, withdrawal and async reset
module tb_rr_grant_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic       done = 1'b0;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    int         vectors = 0;
    int         errs = 0;

    rr_grant_encoder #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] idx, input logic to);
        vectors++;
        assert (gnt_valid === v) else begin
            errs++;
            $error("FAIL %s valid: got %b expected %b", tag, gnt_valid, v);
        end
        vectors++;
        assert (gnt_idx === idx) else begin
            errs++;
            $error("FAIL %s idx: got %0d expected %0d", tag, gnt_idx, idx);
        end
        vectors++;
        assert (timeout === to) else begin
            errs++;
            $error("FAIL %s timeout: got %b expected %b", tag, timeout, to);
        end
    endtask

    initial begin
        #1;
        expect_out("reset", 1'b0, 3'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        expect_out("idle_noreq", 1'b0, 3'd0, 1'b0);
        req = 8'b0010_0100;
        tick();
        expect_out("first_grant", 1'b1, 3'd2, 1'b0);
        req = 8'h00;
        tick();
        expect_out("first_release", 1'b0, 3'd2, 1'b0);
        req = 8'h80;
        done = 1'b1;
        tick();
        expect_out("grant7_pre", 1'b1, 3'd7, 1'b0);
        tick();
        expect_out("release7_pre", 1'b0, 3'd7, 1'b0);
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            expect_out($sformatf("rot_grant%0d", i), 1'b1, 3'(i), 1'b0);
            tick();
            expect_out($sformatf("rot_gap%0d", i), 1'b0, 3'(i), 1'b0);
        end
        req = 8'h80;
        tick();
        expect_out("wrap_grant7", 1'b1, 3'd7, 1'b0);
        tick();
        expect_out("wrap_release7", 1'b0, 3'd7, 1'b0);
        req = 8'h81;
        tick();
        expect_out("wrap_grant0", 1'b1, 3'd0, 1'b0);
        tick();
        done = 1'b0;
        req = 8'h08;
        tick();
        expect_out("to_grant", 1'b1, 3'd3, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            expect_out($sformatf("to_hold%0d", i), 1'b1, 3'd3, 1'b0);
        end
        tick();
        expect_out("to_release", 1'b0, 3'd3, 1'b1);
        tick();
        expect_out("to_regrant", 1'b1, 3'd3, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            expect_out($sformatf("done_hold%0d", i), 1'b1, 3'd3, 1'b0);
        end
        done = 1'b1;
        tick();
        expect_out("done_at_limit", 1'b0, 3'd3, 1'b0);
        done = 1'b0;
        req = 8'h00;
        tick();
        expect_out("idle_again", 1'b0, 3'd3, 1'b0);
        req = 8'h20;
        tick();
        expect_out("wd_grant5", 1'b1, 3'd5, 1'b0);
        req = 8'h00;
        tick();
        expect_out("wd_release", 1'b0, 3'd5, 1'b0);
        req = 8'h41;
        tick();
        expect_out("ptr6_grant", 1'b1, 3'd6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, 3'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_out("post_reset_grant", 1'b1, 3'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
